ravan_job_scheduler: RTL

//  Front-end controller for the RAVAN 512-bit crypto engine. Arbitrates two requesters
//  (round-robin) onto the single shared core issue port, with encrypt/decrypt per job.

---
 rtl/ravan_pkg.sv | 13 +
 rtl/ravan_rsp_fifo.sv | 37 +++
 rtl/ravan_job_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/ravan_pkg.sv
// ravan_pkg: shared widths, opcodes, scheduler states and response entry layout for the RAVAN front end
package ravan_pkg;
  localparam int DATA_W = 64;
  localparam int KEY_W = 512;
  localparam int TAG_W = 4;
  typedef enum logic {OP_DEC = 1'b0, OP_ENC = 1'b1} op_e;
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_LOADKEY} sched_state_e;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              src;
    logic [TAG_W-1:0]  tag;
  } rsp_entry_t;
endpackage

// File: rtl/ravan_rsp_fifo.sv
// ravan_rsp_fifo: synchronous response FIFO with occupancy count for the credit check
module ravan_rsp_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 69
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/ravan_job_scheduler.sv
// ravan_job_scheduler: round-robin issue of two requesters to the fixed-latency RAVAN core,
// tagged result return through a credit-protected FIFO, and drain/load/resume key updates
module ravan_job_scheduler
  import ravan_pkg::*;
#(
  parameter int CORE_LAT   = 4,
  parameter int RESP_DEPTH = 8,
  parameter int TAG_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_op,
  input  logic [2*DATA_W-1:0] req_data,
  input  logic [2*TAG_W-1:0]  req_tag,
  input  logic                key_load_valid,
  output logic                key_load_ready,
  input  logic [KEY_W-1:0]    key_in,
  output logic                core_valid,
  output logic                core_op_sel,
  output logic [DATA_W-1:0]   core_data,
  output logic [KEY_W-1:0]    core_key,
  input  logic [DATA_W-1:0]   core_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_src,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                busy
);
  localparam int CW = $clog2(RESP_DEPTH) + 1;
  localparam int EW = DATA_W + 1 + TAG_W;
  sched_state_e state_q, state_d;
  logic rr_q, rr_d, win, hs, tail, grant_ok;
  logic [CW-1:0] inflight_q, inflight_d, fifo_cnt;
  logic core_valid_q, core_valid_d, core_src_q, core_src_d;
  op_e core_op_q, core_op_d;
  logic [DATA_W-1:0] core_data_q, core_data_d;
  logic [TAG_W-1:0] core_tag_q, core_tag_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [CORE_LAT-1:0] pv_q, pv_d, ps_q, ps_d;
  logic [CORE_LAT*TAG_W-1:0] pt_q, pt_d;
  logic [EW-1:0] fifo_dout;
  always_comb begin
    win = req_valid[rr_q] ? rr_q : (req_valid[~rr_q] ? ~rr_q : rr_q);
    // inflight counts from acceptance, so a granted-but-not-yet-issued job already holds a FIFO slot
    grant_ok = rst_n && state_q == S_RUN && !key_load_valid &&
               ({1'b0, inflight_q} + {1'b0, fifo_cnt} < (CW+1)'(RESP_DEPTH));
    req_ready = grant_ok ? (win ? 2'b10 : 2'b01) : 2'b00;
    hs = |(req_valid & req_ready);
    rr_d = hs ? ~win : rr_q;
    core_valid_d = hs;
    core_op_d = hs ? op_e'(req_op[win]) : core_op_q;
    core_data_d = hs ? (win ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0]) : core_data_q;
    core_src_d = hs ? win : core_src_q;
    core_tag_d = hs ? (win ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0]) : core_tag_q;
    tail = pv_q[CORE_LAT-1];
    pv_d = (pv_q << 1) | CORE_LAT'(core_valid_q);
    ps_d = (ps_q << 1) | CORE_LAT'(core_src_q);
    pt_d = (pt_q << TAG_W) | (CORE_LAT*TAG_W)'(core_tag_q);
    inflight_d = inflight_q + CW'(hs) - CW'(tail);
    state_d = (state_q == S_RUN && key_load_valid) ? S_DRAIN :
              (state_q == S_DRAIN && inflight_q == '0) ? S_LOADKEY :
              (state_q == S_LOADKEY) ? S_RUN : state_q;
    key_load_ready = state_q == S_LOADKEY;
    key_d = key_load_ready ? key_in : key_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_RUN;
      rr_q <= 1'b0;
      inflight_q <= '0;
      core_valid_q <= 1'b0;
      core_op_q <= OP_DEC;
      core_data_q <= '0;
      core_src_q <= 1'b0;
      core_tag_q <= '0;
      key_q <= '0;
      pv_q <= '0;
      ps_q <= '0;
      pt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      inflight_q <= inflight_d;
      core_valid_q <= core_valid_d;
      core_op_q <= core_op_d;
      core_data_q <= core_data_d;
      core_src_q <= core_src_d;
      core_tag_q <= core_tag_d;
      key_q <= key_d;
      pv_q <= pv_d;
      ps_q <= ps_d;
      pt_q <= pt_d;
    end
  ravan_rsp_fifo #(.DEPTH(RESP_DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tail),
    .pop   (rsp_valid && rsp_ready),
    .din   ({core_result, ps_q[CORE_LAT-1], pt_q[CORE_LAT*TAG_W-1 -: TAG_W]}),
    .dout  (fifo_dout),
    .count (fifo_cnt)
  );
  assign rsp_valid = fifo_cnt != '0;
  assign {rsp_data, rsp_src, rsp_tag} = rsp_valid ? fifo_dout : '0;
  assign core_valid = core_valid_q;
  assign core_op_sel = core_op_q;
  assign core_data = core_data_q;
  assign core_key = key_q;
  assign busy = inflight_q != '0 || rsp_valid || state_q != S_RUN;
endmodule
